qsys_lab2_mem_pattern_tester: RTL
=================================

// Module: qsys_lab2_mem_pattern_tester
// PURPOSE
//  Upstream master for the 32-bit single-port on-chip RAM (s1 port, 1-cycle read latency).
//  On start: writes a pattern over a word range, reads it back, compares, reports errors.
//  Used for board bring-up and RAM self-test before the CPU owns the memory.
// PARAMETERS
//  ADDR_W   14     RAM word-address width
//  DEPTH    10000  RAM words; addresses wrap modulo DEPTH
//  ERR_W    16     error-counter width, saturating
// PORTS
//  clk             in   1       system clock
//  reset           in   1       synchronous, active-high
//  start           in   1       1-cycle pulse; ignored unless idle
//  abort           in   1       1-cycle pulse; ends run, sets done
//  mode            in   1       0 = LFSR data, 1 = data = zero-extended address
//  base            in   ADDR_W  first word address, sampled at start; must be < DEPTH
//  count           in   ADDR_W+1 words to test, sampled at start; clamped to DEPTH
//  seed            in   32      LFSR seed, sampled at start; 0 is replaced by 32'h1
//  busy            out  1       high from cycle after start until done
//  done            out  1       sticky; cleared by next accepted start
//  error           out  1       sticky; any mismatch in the current run
//  err_count       out  ERR_W   mismatches, saturates at all-ones
//  first_err_addr  out  ADDR_W  address of first mismatch; 0 if none
//  mem_address     out  ADDR_W  to RAM address
//  mem_byteenable  out  4       always 4'hF
//  mem_chipselect  out  1       high during WR and RD issue cycles only
//  mem_write       out  1       high in WR state only
//  mem_writedata   out  32      pattern word
//  mem_clken       out  1       constant 1
//  mem_readdata    in   32      from RAM q, valid 1 cycle after read issue
// BEHAVIOUR
//  Reset: state IDLE; busy, done, error, mem_chipselect, mem_write = 0; err_count,
//   first_err_addr, mem_address, mem_writedata = 0.
//  FSM IDLE -> WR -> RD -> DRAIN -> IDLE.
//   IDLE: start latches base/count/seed; count==0 -> done=1 next cycle, no RAM access.
//   WR: one write per cycle, address base+i mod DEPTH, i = 0..count-1; last word -> RD.
//   RD: pattern generator reloaded from latched seed; one read per cycle, same sequence.
//   DRAIN: one cycle to compare final read word -> IDLE with done=1, busy=0.
//  Data: mode 0 = Galois LFSR x^32+x^22+x^2+x+1, advances once per issued word,
//   word 0 = seed; mode 1 = {zeros, address}.
//  Compare pipeline: expected word and address registered with each read issue;
//   compared against mem_readdata next cycle, qualified by a 1-bit valid.
//  Mismatch: error=1, err_count+1 (saturating), first_err_addr captured only when
//   err_count was 0.
//  Wrap: address DEPTH-1 is followed by 0; the count clamp means no word is written twice.
//  abort: finishes the in-flight compare (DRAIN), then done=1; further WR/RD is skipped.
//  start while busy: ignored. start and abort in the same cycle in IDLE: start wins.
//  Reset during a run: immediate return to reset values; the partial RAM contents are
//   undefined.
//  Total latency: 2*count + 2 cycles from start to done.
// STRUCTURE
//  Package qsys_lab2_mem_test_pkg: state enum, LFSR tap constant 32'h0040_0007,
//   default seed 32'h1.
//  Sub-module qsys_lab2_lfsr32: load, advance, q; one instance, reloaded at the RD phase.
// TESTING
//  Model RAM: behavioural 1-cycle-latency memory with DEPTH=10000.
//  T1: base=0, count=16, mode=1 -> 16 writes, then 16 reads; done at start+34,
//   error=0, err_count=0.
//  T2: base=9998, count=4, mode=0, seed=0 -> addresses 9998,9999,0,1; seed treated as 1;
//   no error.
//  T3: model corrupts address 5 readback (bit 0 flipped); base=0, count=10 -> error=1,
//   err_count=1, first_err_addr=5.
//  T4: count=0 -> done one cycle after start, no chipselect asserted, busy pulse <= 1 cycle.
//  T5: abort in WR at i=3 -> no further writes, done=1, busy=0 within 2 cycles;
//   a second start is accepted.
//  T6: reset asserted mid-RD -> next cycle all outputs at reset values; start during
//   busy is ignored (counter check).

Source files
------------

// File: rtl/qsys_lab2_mem_test_pkg.sv
// Shared types and constants for the on-chip RAM pattern tester.
// The LFSR polynomial is x^32+x^22+x^2+x+1, stepped in left-shifting Galois form.
package qsys_lab2_mem_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS    = 32'h0040_0007;
  localparam logic [31:0] DEFAULT_SEED = 32'h1;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/qsys_lab2_mem_pattern_tester_if.sv
// Avalon-MM style s1 port of the single-port on-chip RAM, seen from the tester.
interface qsys_lab2_mem_pattern_tester_if #(
  parameter int ADDR_W = 14
);
  // No backpressure: every cycle with mem_chipselect high is an accepted command
  // (write when mem_write is high, read otherwise); read data is valid exactly
  // one cycle after the read command cycle.
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/qsys_lab2_lfsr32.sv
// 32-bit Galois LFSR pattern source; load takes priority over advance.
module qsys_lab2_lfsr32
  import qsys_lab2_mem_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 32'h0;
    end else if (load) begin
      q <= seed;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/qsys_lab2_mem_pattern_tester.sv
// RAM self-test master: writes a pattern over a wrapped word range, reads it back
// through a one-deep compare pipeline and reports mismatches.
module qsys_lab2_mem_pattern_tester
  import qsys_lab2_mem_test_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 10000,
  parameter int ERR_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    base,
  input  logic [ADDR_W:0]      count,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output state_t               state_dbg,
  qsys_lab2_mem_pattern_tester_if.master mem
);

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [CNT_W-1:0]  cnt_q, idx_q;
  logic [31:0]       seed_q;
  logic              mode_q;
  logic [31:0]       lfsr_q;
  logic [31:0]       pattern;
  logic              cmp_valid;
  logic [31:0]       exp_data;
  logic [ADDR_W-1:0] exp_addr;

  logic              accept, finish, issue_rd;
  logic              lfsr_load, lfsr_adv, addr_step, addr_reload;
  logic [31:0]       lfsr_seed, seed_eff;
  logic [CNT_W-1:0]  count_eff;
  logic              last;

  qsys_lab2_lfsr32 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (lfsr_seed),
    .q       (lfsr_q)
  );

  assign seed_eff  = (seed == 32'h0) ? DEFAULT_SEED : seed;
  assign count_eff = (count > DEPTH_C) ? DEPTH_C : count;
  assign last      = (idx_q == cnt_q - CNT_W'(1));
  assign pattern   = mode_q ? {{(32-ADDR_W){1'b0}}, addr_q} : lfsr_q;

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    finish      = 1'b0;
    issue_rd    = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;
    lfsr_seed   = seed_q;
    addr_step   = 1'b0;
    addr_reload = 1'b0;
    case (state)
      ST_IDLE: begin
        // start beats a simultaneous abort; an empty range completes without touching RAM
        if (start) begin
          accept = 1'b1;
          if (count_eff == '0) begin
            finish = 1'b1;
          end else begin
            state_nxt = ST_WR;
            lfsr_load = 1'b1;
            lfsr_seed = seed_eff;
          end
        end
      end
      ST_WR: begin
        if (abort) begin
          state_nxt = ST_DRAIN;
        end else if (last) begin
          state_nxt   = ST_RD;
          lfsr_load   = 1'b1;
          addr_reload = 1'b1;
        end else begin
          lfsr_adv  = 1'b1;
          addr_step = 1'b1;
        end
      end
      ST_RD: begin
        issue_rd = 1'b1;
        if (abort || last) begin
          state_nxt = ST_DRAIN;
        end else begin
          lfsr_adv  = 1'b1;
          addr_step = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_IDLE;
        finish    = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      base_q         <= '0;
      addr_q         <= '0;
      cnt_q          <= '0;
      idx_q          <= '0;
      seed_q         <= DEFAULT_SEED;
      mode_q         <= 1'b0;
      cmp_valid      <= 1'b0;
      exp_data       <= '0;
      exp_addr       <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state     <= state_nxt;
      cmp_valid <= issue_rd;
      if (issue_rd) begin
        exp_data <= pattern;
        exp_addr <= addr_q;
      end

      if (cmp_valid && (mem.mem_readdata != exp_data)) begin
        error <= 1'b1;
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        if (err_count == '0) first_err_addr <= exp_addr;
      end

      if (addr_step) begin
        addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        idx_q  <= idx_q + CNT_W'(1);
      end else if (addr_reload) begin
        addr_q <= base_q;
        idx_q  <= '0;
      end

      if (accept) begin
        base_q         <= base;
        addr_q         <= base;
        cnt_q          <= count_eff;
        idx_q          <= '0;
        seed_q         <= seed_eff;
        mode_q         <= mode;
        done           <= 1'b0;
        error          <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end
      if (finish) done <= 1'b1;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  assign mem.mem_address    = addr_q;
  assign mem.mem_byteenable = 4'hF;
  assign mem.mem_chipselect = (state == ST_WR) || (state == ST_RD);
  assign mem.mem_write      = (state == ST_WR);
  assign mem.mem_writedata  = pattern;
  assign mem.mem_clken      = 1'b1;

endmodule
